// File: rtl/pmem_acc_pkg.sv
// -----------------------------------------------------------------------------
// pmem_acc_pkg
// Shared definitions for the partial-sum accumulation memory:
//   - pmem_state_e     : controller states (IDLE / CLEAR)
//   - default geometry : data and address widths
//   - pmem_sat_max/min : signed saturation bounds for any word width, returned
//                        as 64-bit patterns that callers truncate to their width
// -----------------------------------------------------------------------------
package pmem_acc_pkg;

    localparam int PMEM_DW_DEFAULT = 24;
    localparam int PMEM_AW_DEFAULT = 6;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } pmem_state_e;

    // Largest positive two's complement value of a w-bit word.
    function automatic logic [63:0] pmem_sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's complement value of a w-bit word (bit pattern 10..0).
    function automatic logic [63:0] pmem_sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/pmem_acc_array.sv
// -----------------------------------------------------------------------------
// pmem_acc_array
// Storage for pmem_acc: one synchronous write port and two asynchronous read
// ports (read-modify-write port and host read port). Contents are never reset.
// Kept as its own module so it can be replaced by a memory macro.
// Ports:
//   i_clk                  clock
//   i_we/i_waddr/i_wdata   write port
//   i_raddr_a / o_rdata_a  async read port A (accumulate read)
//   i_raddr_b / o_rdata_b  async read port B (host read)
// -----------------------------------------------------------------------------
module pmem_acc_array
    import pmem_acc_pkg::*;
#(
    parameter int DATA_WIDTH = PMEM_DW_DEFAULT,
    parameter int ADDR_WIDTH = PMEM_AW_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr_a,
    output logic [DATA_WIDTH-1:0] o_rdata_a,
    input  logic [ADDR_WIDTH-1:0] i_raddr_b,
    output logic [DATA_WIDTH-1:0] o_rdata_b
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    // Single write port; no reset so the array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a = mem_q[i_raddr_a];
    assign o_rdata_b = mem_q[i_raddr_b];

endmodule

// File: rtl/pmem_acc.sv
// -----------------------------------------------------------------------------
// pmem_acc
// Partial-sum memory with overwrite, pipelined accumulate, 1-cycle reads and a
// sequential full-array clear.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_wr_en, i_acc_en      write request; accumulate (1) or overwrite (0)
//   i_wr_addr, i_wr_data   write address and data/addend
//   i_rd_en, i_rd_addr     read request and address
//   i_clr                  pulse starting the clear sequence
//   o_rd_data, o_rd_valid  registered read data and its valid strobe
//   o_busy                 clear in progress, requests ignored
// Build option:
//   PMEM_ACC_SAT_EN        accumulate saturates to signed max/min instead of
//                          wrapping modulo 2**DATA_WIDTH
// -----------------------------------------------------------------------------
module pmem_acc
    import pmem_acc_pkg::*;
#(
    parameter int DATA_WIDTH = PMEM_DW_DEFAULT,
    parameter int ADDR_WIDTH = PMEM_AW_DEFAULT
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic                  i_acc_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic                  i_clr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

`ifdef PMEM_ACC_SAT_EN
    localparam logic [DATA_WIDTH-1:0] SUM_MAX = DATA_WIDTH'(pmem_sat_max(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] SUM_MIN = DATA_WIDTH'(pmem_sat_min(DATA_WIDTH));
`endif

    // Controller state
    pmem_state_e           state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;

    // Stage 2 of the accumulate pipeline: a finished sum waiting to be written
    logic                  acc_vld_q, acc_vld_d;
    logic [ADDR_WIDTH-1:0] acc_addr_q, acc_addr_d;
    logic [DATA_WIDTH-1:0] acc_sum_q, acc_sum_d;

    // Read output registers
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;

    // Request qualification
    logic                  idle_s;
    logic                  clr_start_s;
    logic                  req_ok_s;
    logic                  ovw_s;
    logic                  acc_s;
    logic                  rd_s;

    // Datapath
    logic [DATA_WIDTH-1:0] rmw_rdata_s;
    logic [DATA_WIDTH-1:0] host_rdata_s;
    logic [DATA_WIDTH-1:0] old_s;
    logic [DATA_WIDTH-1:0] sum_s;
    logic [DATA_WIDTH-1:0] rd_bypass_s;
`ifdef PMEM_ACC_SAT_EN
    logic [DATA_WIDTH:0]   sum_wide_s;
`endif

    // Array write port
    logic                  mem_we_s;
    logic [ADDR_WIDTH-1:0] mem_waddr_s;
    logic [DATA_WIDTH-1:0] mem_wdata_s;

    // A clear request takes the whole cycle: same-cycle reads and writes are
    // dropped because the array is about to be zeroed anyway.
    assign idle_s      = (state_q == ST_IDLE);
    assign clr_start_s = idle_s & i_clr;
    assign req_ok_s    = idle_s & ~i_clr;
    assign ovw_s       = req_ok_s & i_wr_en & ~i_acc_en;
    assign acc_s       = req_ok_s & i_wr_en & i_acc_en;
    assign rd_s        = req_ok_s & i_rd_en;

    // Forward the pending stage-2 sum so back-to-back accumulates chain.
    assign old_s       = (acc_vld_q && (acc_addr_q == i_wr_addr)) ? acc_sum_q : rmw_rdata_s;
    // Reads see a sum still waiting in stage 2.
    assign rd_bypass_s = (acc_vld_q && (acc_addr_q == i_rd_addr)) ? acc_sum_q : host_rdata_s;

    pmem_acc_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .i_clk     (i_clk),
        .i_we      (mem_we_s),
        .i_waddr   (mem_waddr_s),
        .i_wdata   (mem_wdata_s),
        .i_raddr_a (i_wr_addr),
        .o_rdata_a (rmw_rdata_s),
        .i_raddr_b (i_rd_addr),
        .o_rdata_b (host_rdata_s)
    );

    // Signed add of old entry and addend, wrapping or saturating.
    always_comb begin
`ifdef PMEM_ACC_SAT_EN
        sum_wide_s = {old_s[DATA_WIDTH-1], old_s} + {i_wr_data[DATA_WIDTH-1], i_wr_data};
        // The two top bits of the widened sum differ only on signed overflow;
        // the top bit is the sign of the true result.
        if (sum_wide_s[DATA_WIDTH] != sum_wide_s[DATA_WIDTH-1]) begin
            if (sum_wide_s[DATA_WIDTH]) begin
                sum_s = SUM_MIN;
            end else begin
                sum_s = SUM_MAX;
            end
        end else begin
            sum_s = sum_wide_s[DATA_WIDTH-1:0];
        end
`else
        sum_s = old_s + i_wr_data;
`endif
    end

    // Write port arbitration: clear, then overwrite, then stage-2 commit.
    // A stage-2 sum that loses to an overwrite at another address simply waits.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_waddr_s = '0;
        mem_wdata_s = '0;
        if (i_rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = clr_cnt_q;
            mem_wdata_s = '0;
        end else if (ovw_s) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = i_wr_addr;
            mem_wdata_s = i_wr_data;
        end else if (acc_vld_q) begin
            mem_we_s    = 1'b1;
            mem_waddr_s = acc_addr_q;
            mem_wdata_s = acc_sum_q;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Stage-2 next state: load a new sum, hold behind an overwrite elsewhere,
    // or retire (committed, or discarded by an overwrite of the same entry).
    always_comb begin
        acc_vld_d  = acc_vld_q;
        acc_addr_d = acc_addr_q;
        acc_sum_d  = acc_sum_q;
        if (acc_s) begin
            acc_vld_d  = 1'b1;
            acc_addr_d = i_wr_addr;
            acc_sum_d  = sum_s;
        end else if (ovw_s && acc_vld_q && (acc_addr_q != i_wr_addr)) begin
            acc_vld_d = 1'b1;
        end else begin
            acc_vld_d = 1'b0;
        end
    end

    // Clear sequencer: one zero write per cycle from address 0 upward.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (i_clr) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d   = ST_IDLE;
                clr_cnt_d = '0;
            end
        endcase
    end

    // Read output: capture on accepted read, otherwise hold data, drop valid.
    always_comb begin
        rd_valid_d = rd_s;
        if (rd_s) begin
            rd_data_d = rd_bypass_s;
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            clr_cnt_q  <= '0;
            acc_vld_q  <= 1'b0;
            acc_addr_q <= '0;
            acc_sum_q  <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            acc_vld_q  <= acc_vld_d;
            acc_addr_q <= acc_addr_d;
            acc_sum_q  <= acc_sum_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign o_rd_data  = rd_data_q;
    assign o_rd_valid = rd_valid_q;
    assign o_busy     = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_pmem_acc.sv
// -----------------------------------------------------------------------------
// tb_pmem_acc
// Self-checking bench for pmem_acc (DATA_WIDTH=24, ADDR_WIDTH=6). The reference
// model is a plain array updated in request order; each accepted read pushes
// its expected value into a queue, and a monitor pops and compares whenever
// the DUT presents o_rd_valid.
// -----------------------------------------------------------------------------
module tb_pmem_acc;

    localparam int DW    = 24;
    localparam int AW    = 6;
    localparam int DEPTH = 64;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_wr_en = 1'b0;
    logic          i_acc_en = 1'b0;
    logic [AW-1:0] i_wr_addr = '0;
    logic [DW-1:0] i_wr_data = '0;
    logic          i_rd_en = 1'b0;
    logic [AW-1:0] i_rd_addr = '0;
    logic          i_clr = 1'b0;
    logic [DW-1:0] o_rd_data;
    logic          o_rd_valid;
    logic          o_busy;

    typedef struct packed {
        logic          known;
        logic [DW-1:0] val;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m[DEPTH];
    bit            mk[DEPTH];
    int            n_chk  = 0;
    int            n_fail = 0;

    pmem_acc #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_wr_en    (i_wr_en),
        .i_acc_en   (i_acc_en),
        .i_wr_addr  (i_wr_addr),
        .i_wr_data  (i_wr_data),
        .i_rd_en    (i_rd_en),
        .i_rd_addr  (i_rd_addr),
        .i_clr      (i_clr),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .o_busy     (o_busy)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    // Signed 24-bit sum as the reference arithmetic defines it.
    function automatic logic [DW-1:0] model_add(logic [DW-1:0] a, logic [DW-1:0] b);
        longint s;
        s = longint'($signed(a)) + longint'($signed(b));
`ifdef PMEM_ACC_SAT_EN
        if (s > 64'sd8388607)  s = 64'sd8388607;
        if (s < -64'sd8388608) s = -64'sd8388608;
`endif
        return s[DW-1:0];
    endfunction

    // One request cycle; reads see the model before this cycle's write.
    task automatic cyc(bit wr, bit acc, int wa, logic [DW-1:0] wd, bit rd, int ra);
        exp_t e;
        i_wr_en   = wr;
        i_acc_en  = acc;
        i_wr_addr = AW'(wa);
        i_wr_data = wd;
        i_rd_en   = rd;
        i_rd_addr = AW'(ra);
        i_clr     = 1'b0;
        if (rd) begin
            e.known = mk[ra];
            e.val   = m[ra];
            exp_q.push_back(e);
        end
        if (wr) begin
            if (acc) begin
                if (mk[wa]) m[wa] = model_add(m[wa], wd);
            end else begin
                m[wa]  = wd;
                mk[wa] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 0, '0, 1'b0, 0);
    endtask

    task automatic read_all();
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, 1'b0, 0, '0, 1'b1, a);
        idle(2);
    endtask

    // Full clear with junk requests during busy; they must have no effect.
    task automatic do_clear();
        int cnt;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        i_clr   = 1'b1;
        @(posedge clk);
        #1;
        cnt = 0;
        while (o_busy === 1'b1 && cnt < 200) begin
            i_clr     = 1'($urandom_range(0, 1));
            i_wr_en   = 1'($urandom_range(0, 1));
            i_acc_en  = 1'($urandom_range(0, 1));
            i_wr_addr = AW'($urandom_range(0, DEPTH - 1));
            i_wr_data = DW'($urandom);
            i_rd_en   = 1'($urandom_range(0, 1));
            i_rd_addr = AW'($urandom_range(0, DEPTH - 1));
            @(posedge clk);
            #1;
            cnt++;
        end
        i_clr   = 1'b0;
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        check("busy_cycles", cnt, 64);
        for (int a = 0; a < DEPTH; a++) begin
            m[a]  = '0;
            mk[a] = 1'b1;
        end
    endtask

    // Monitor: every o_rd_valid must match the oldest expected read.
    always @(negedge clk) begin
        exp_t e;
        if (o_rd_valid === 1'b1) begin
            if (o_busy === 1'b1) begin
                n_chk++;
                n_fail++;
                $display("FAIL rd_valid_while_busy: got 1 expected 0");
            end
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_rd_valid: got data %0d expected no read", o_rd_data);
            end else begin
                e = exp_q.pop_front();
                if (e.known) check("rd_data", longint'(o_rd_data), longint'(e.val));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int a = 0; a < DEPTH; a++) begin
            m[a]  = '0;
            mk[a] = 1'b0;
        end

        // Reset values
        i_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_valid", longint'(o_rd_valid), 0);
        check("rst_rd_data",  longint'(o_rd_data), 0);
        check("rst_busy",     longint'(o_busy), 0);
        i_rst = 1'b0;
        idle(2);

        // Clear sequence, then every entry reads zero
        do_clear();
        read_all();

        // Overwrite then read on the next cycle
        cyc(1'b1, 1'b0, 5, 24'd100, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, '0, 1'b1, 5);
        idle(2);

        // Four chained accumulates then immediate read (forward + bypass)
        for (int k = 0; k < 4; k++) cyc(1'b1, 1'b1, 3, 24'd7, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, '0, 1'b1, 3);
        idle(2);

        // Positive overflow: saturate or wrap depending on build
        cyc(1'b1, 1'b0, 9, 24'd8388600, 1'b0, 0);
        cyc(1'b1, 1'b1, 9, 24'd10, 1'b0, 0);
        cyc(1'b0, 1'b0, 0, '0, 1'b1, 9);
        idle(2);

        // Overwrite landing while the accumulate commits wins; the read in
        // that same cycle still sees the accumulated value
        cyc(1'b1, 1'b0, 2, 24'd1, 1'b0, 0);
        cyc(1'b1, 1'b1, 2, 24'd5, 1'b0, 0);
        cyc(1'b1, 1'b0, 2, 24'd50, 1'b1, 2);
        cyc(1'b0, 1'b0, 0, '0, 1'b1, 2);
        idle(2);

        // Pending accumulate delayed by an overwrite elsewhere
        cyc(1'b1, 1'b0, 4, 24'd11, 1'b0, 0);
        cyc(1'b1, 1'b1, 4, 24'd3, 1'b0, 0);
        cyc(1'b1, 1'b0, 6, 24'd77, 1'b1, 4);
        cyc(1'b1, 1'b1, 4, 24'd2, 1'b1, 6);
        cyc(1'b0, 1'b0, 0, '0, 1'b1, 4);
        idle(2);

        // Randomized traffic on a small address window for heavy collisions
        for (int k = 0; k < 600; k++) begin
            logic [DW-1:0] d;
            if ($urandom_range(0, 3) == 0) d = DW'($urandom);
            else d = DW'($urandom_range(0, 40)) - DW'(20);
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 7), d,
                1'($urandom_range(0, 1)), $urandom_range(0, 7));
        end
        idle(2);
        read_all();

        // Reset in the middle of a clear leaves a partially cleared array
        for (int a = 0; a < DEPTH; a++) cyc(1'b1, 1'b0, a, DW'(1000 + a), 1'b0, 0);
        i_clr = 1'b1;
        @(posedge clk);
        #1;
        i_clr = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_before_abort", longint'(o_busy), 1);
        i_rst = 1'b1;
        @(posedge clk);
        #1;
        i_rst = 1'b0;
        check("abort_busy",     longint'(o_busy), 0);
        check("abort_rd_valid", longint'(o_rd_valid), 0);
        check("abort_rd_data",  longint'(o_rd_data), 0);
        for (int a = 0; a < 10; a++) m[a] = '0;
        idle(1);
        read_all();

        idle(3);
        check("reads_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pmem_acc.md
PMEM_ACC -- requirements
Module: pmem_acc

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, psum word width in bits (two's complement).
REQ-002 SHALL have parameter ADDR_WIDTH, default 6, address width; depth DEPTH = 2**ADDR_WIDTH entries.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port i_rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port i_wr_en, input, 1, write request.
REQ-006 SHALL have port i_acc_en, input, 1, qualifies i_wr_en: 1 = accumulate into entry, 0 = overwrite.
REQ-007 SHALL have port i_wr_addr, input, ADDR_WIDTH, write/accumulate address.
REQ-008 SHALL have port i_wr_data, input, DATA_WIDTH, write data or addend.
REQ-009 SHALL have port i_rd_en, input, 1, read request.
REQ-010 SHALL have port i_rd_addr, input, ADDR_WIDTH, read address.
REQ-011 SHALL have port i_clr, input, 1, single-cycle pulse starting a full-array clear.
REQ-012 SHALL have port o_rd_data, output, DATA_WIDTH, read data, registered.
REQ-013 SHALL have port o_rd_valid, output, 1, o_rd_data valid this cycle.
REQ-014 SHALL have port o_busy, output, 1, clear sequence in progress; requests ignored.

Function
REQ-015 Overwrite (i_wr_en=1, i_acc_en=0) SHALL commit i_wr_data at the edge it is sampled.
REQ-016 Accumulate SHALL be a 2-stage pipeline: stage 1 captures addr/data and reads the old entry; stage 2 writes old+data one cycle later.
REQ-017 Back-to-back accumulates to the same address SHALL forward stage-2 sum into stage 1, so N consecutive accumulates of value v add exactly N*v.
REQ-018 An overwrite sampled while stage 2 commits the same address SHALL win; the stage-2 accumulate to that address is discarded.
REQ-019 Read latency SHALL be 1 cycle: o_rd_valid=1 and o_rd_data valid the cycle after i_rd_en=1; o_rd_valid=0 otherwise, o_rd_data holds last value.
REQ-020 Reads SHALL observe every write/accumulate sampled in an earlier cycle, including one still in stage 2 (bypass); writes in the same cycle are not observed.
REQ-021 Sum arithmetic SHALL be signed DATA_WIDTH; overflow behaviour per Configuration.
REQ-022 FSM states IDLE and CLEAR; IDLE->CLEAR on i_clr=1 while IDLE; CLEAR writes 0 to one entry per cycle from address 0 upward; CLEAR->IDLE after entry DEPTH-1 is written (DEPTH cycles of o_busy=1).
REQ-023 i_clr SHALL be sampled only in IDLE; a pending stage-2 accumulate at i_clr SHALL complete before the address-0 clear write and is then zeroed.
REQ-024 While o_busy=1, i_wr_en, i_rd_en and i_clr SHALL be ignored and o_rd_valid SHALL stay 0.
REQ-025 Unwritten, uncleared entries SHALL read as undefined; no X-propagation checks on them.

Reset
REQ-026 On i_rst=1: o_rd_data=0, o_rd_valid=0, o_busy=0, FSM=IDLE, clear counter=0, stage-2 valid=0.
REQ-027 Reset SHALL NOT initialise array contents; reset during CLEAR aborts the sequence, leaving a partially cleared array.
REQ-028 Reset SHALL dominate all inputs in the same cycle.

Configuration
REQ-029 Macro PMEM_ACC_SAT_EN defined: accumulate results saturate to max/min signed DATA_WIDTH value.
REQ-030 Macro PMEM_ACC_SAT_EN undefined: accumulate results wrap modulo 2**DATA_WIDTH; no saturation logic present.

Structure
REQ-031 A shared package SHALL hold the FSM state enum (IDLE, CLEAR) and the signed saturate/add helper constants (max/min per width).
REQ-032 The storage array SHALL be a sub-module pmem_acc_array (1 write port, 2 async read ports: RMW and read path) so it can be swapped for a macro.

Verification
REQ-033 Reset, i_clr, wait DEPTH=64 cycles -> o_busy high exactly 64 cycles; then read all 64 addresses -> every o_rd_data=0.
REQ-034 Overwrite addr 5 = 100, next cycle read addr 5 -> o_rd_valid=1, o_rd_data=100 one cycle later.
REQ-035 After clear, 4 consecutive accumulates of 7 to addr 3, read addr 3 the cycle after the last -> 28 (forwarding and bypass).
REQ-036 DATA_WIDTH=24, addr 9 = 8388600, accumulate 10 -> with PMEM_ACC_SAT_EN reads 8388607; without reads -8388606.
REQ-037 Accumulate 5 to addr 2 (holding 1) then overwrite addr 2 = 50 next cycle -> reads 50.
REQ-038 i_clr then i_rst at cycle 10 of CLEAR -> o_busy=0 next cycle; addr 0-9 read 0, addr 10+ retain prior values.
